lsu_unit: RTL
=============

Name: lsu_unit

Overview:
Load/store unit sitting directly downstream of the execute stage: it consumes the ALU-computed effective address, store data and func3 from the datapath, and drives a 64-bit data-memory port with a valid/ready handshake. It performs store byte-lane masking, load lane extraction and sign/zero extension, and misalignment detection. It replaces the combinational single-cycle memory path with a multi-cycle, handshaked access.

Parameters:
ADDR_WIDTH, 64, width of effective and memory addresses.
DATA_WIDTH, 64, register and memory data width; only 64 is supported, giving an 8-bit byte mask.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-low: rst==0 at a rising clk edge resets the block.
req_valid  in  1  execute stage presents a memory op.
req_ready  out  1  unit can accept; high only in IDLE.
req_wen  in  1  1 = store, 0 = load.
req_func3  in  3  RV64 funct3 (load: LB/LH/LW/LD/LBU/LHU/LWU; store: SB/SH/SW/SD).
req_addr  in  ADDR_WIDTH  effective byte address.
req_wdata  in  DATA_WIDTH  store data, right-aligned (rs2).
resp_valid  out  1  result available.
resp_ready  in  1  consumer accepts result.
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned access or illegal load func3 (111).
mem_req_valid  out  1  memory request.
mem_req_ready  in  1  memory accepts request.
mem_addr  out  ADDR_WIDTH  req_addr with bits [2:0] forced to 0.
mem_wen  out  1  write request.
mem_wmask  out  8  byte-lane write enables.
mem_wdata  out  DATA_WIDTH  lane-shifted store data.
mem_rsp_valid  in  1  memory response or store acknowledge.
mem_rsp_rdata  in  DATA_WIDTH  aligned 64-bit read data.

Behaviour:
- Reset (rst==0 at an edge): state IDLE; req_ready=1; resp_valid, resp_err, mem_req_valid, mem_wen=0; mem_wmask=0; resp_rdata, mem_addr, mem_wdata=0. Reset in any state aborts the in-flight op; a late mem_rsp_valid arriving in IDLE is ignored.
- FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
- IDLE: when req_valid, latch addr, wen, func3 and wdata. If the op is misaligned or illegal, go to RESP with resp_err=1 and issue no memory access. Otherwise go to REQ.
- REQ: mem_req_valid=1, with all mem_* outputs stable until the edge where mem_req_ready=1, then go to WAIT. mem_rsp_valid is not sampled in REQ.
- WAIT: on mem_rsp_valid, capture the extended data (loads) or 0 (stores), then go to RESP.
- RESP: resp_valid=1, with resp_* held stable until resp_ready=1, then go to IDLE. A new request can be accepted no earlier than the cycle after the response handshake.
- Minimum latency with ready/valid asserted immediately: accept at edge 0, mem request at edge 1, response captured at edge 2, resp_valid visible after edge 2, i.e. 3 cycles request-to-result.
- Size is func3[1:0]: 0=byte, 1=half, 2=word, 3=dword. Loads zero-extend when func3[2]=1.
- Misalignment: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
- Store mask and data: mask = {1,3,15,255}[size] << addr[2:0]; mem_wdata = req_wdata << (8*addr[2:0]). Bytes outside the mask are don't-care.
- Load: shifted = mem_rsp_rdata >> (8*addr[2:0]). Take the low 8/16/32/64 bits, then sign-extend (func3[2]=0) or zero-extend (func3[2]=1).
- Store func3[2]=1 is illegal and sets resp_err=1.
- For loads, mem_wen=0 and mem_wmask=0.

Decomposition:
- Shared package lsu_pkg holds:
  - the state enum {IDLE, REQ, WAIT, RESP};
  - size constants SZ_B/SZ_H/SZ_W/SZ_D;
  - funct3 localparams (F3_LB, F3_LBU, ...);
  - the function misaligned(size, addr[2:0]).
- One combinational sub-module, lsu_align, produces wmask/wdata from (size, addr[2:0], wdata) and the extended rdata from (func3, addr[2:0], raw rdata).
- The FSM and registers stay in lsu_unit.

Test Plan:
- SD addr 0x80000010, wdata 0x1122334455667788, mem_req_ready=1 -> mem_addr 0x80000010, wmask 0xFF, wdata unchanged; resp_valid 3 cycles after accept, resp_err=0.
- SB addr 0x80000013, wdata 0xAB -> mem_addr 0x80000010, wmask 0x08, mem_wdata[31:24]=0xAB.
- LB addr 0x80000005, mem_rsp_rdata 0x0000_8000_0000_0000 -> resp_rdata 0xFFFFFFFFFFFFFF80; LBU with the same inputs -> 0x80.
- LW addr 0x80000002 -> resp_err=1, resp_rdata 0, mem_req_valid never asserted, resp_valid one cycle after accept.
- Backpressure: mem_req_ready low for 4 cycles, then resp_ready low for 3 cycles -> mem_* outputs and resp_* outputs held stable throughout, req_ready=0 until the response handshake completes.
- rst=0 while in WAIT, then a stray mem_rsp_valid in IDLE -> next cycle all outputs at reset values, no resp_valid generated.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size codes, funct3 values and alignment helper for the LSU
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LD      = 3'b011;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_LWU     = 3'b110;
    localparam logic [2:0] F3_LILLEGAL = 3'b111;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_SD      = 3'b011;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        case (size)
            SZ_H:    misaligned = addr_lo[0];
            SZ_W:    misaligned = |addr_lo[1:0];
            SZ_D:    misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane placement and load lane extraction with sign/zero extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wmask,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);

    logic [7:0]  base_mask;
    logic [63:0] shifted;

    always_comb begin
        base_mask = 8'hFF;
        case (func3[1:0])
            SZ_B:    base_mask = 8'h01;
            SZ_H:    base_mask = 8'h03;
            SZ_W:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        wmask    = base_mask << addr_lo;
        wdata_sh = wdata << {addr_lo, 3'b000};
        shifted  = rdata >> {addr_lo, 3'b000};

        // func3[2] selects zero extension for loads
        rdata_ext = shifted;
        case (func3[1:0])
            SZ_B: rdata_ext = func3[2] ? {56'b0, shifted[7:0]}
                                       : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: rdata_ext = func3[2] ? {48'b0, shifted[15:0]}
                                       : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: rdata_ext = func3[2] ? {32'b0, shifted[31:0]}
                                       : {{32{shifted[31]}}, shifted[31:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - handshaked load/store unit between execute stage and 64-bit data memory
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_func3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [7:0]            mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

    lsu_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [2:0]            func3_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  req_bad;
    logic [7:0]            wmask;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rdata_ext;

    // Stores have no unsigned forms; loads reserve only 111
    assign req_bad = misaligned(req_func3[1:0], req_addr[2:0])
                   | (req_wen ? req_func3[2] : (req_func3 == F3_LILLEGAL));

    lsu_align u_align (
        .func3     (func3_q),
        .addr_lo   (addr_q[2:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rsp_rdata),
        .wmask     (wmask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_bad ? RESP : REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            func3_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wen_q   <= req_wen;
                func3_q <= req_func3;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
                rdata_q <= '0;
            end
            if (state == WAIT && mem_rsp_valid) rdata_q <= wen_q ? '0 : rdata_ext;
        end
    end

    assign mem_addr   = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign mem_wen    = (state == REQ) && wen_q;
    assign mem_wmask  = mem_wen ? wmask : 8'h00;
    assign mem_wdata  = wdata_sh;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
